demux4x8bit_stream: RTL and testbench
=====================================

# demux4x8bit_stream

Registered 1-to-4 byte demultiplexer with valid/ready handshaking on both sides, the steering counterpart of the 4-way selectors used in the datapath. It accepts one byte per cycle tagged with a 2-bit destination and holds it in a one-entry register for that output channel until the consumer takes it. Each channel keeps a wrapping count of delivered bytes for debug and bring-up. It sits between a single producer, such as the memory read path, and up to four consumers.

## Interface
- WIDTH, 8, data width per channel.
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  input  1  producer has a byte on in_data.
- in_data  input  WIDTH  byte to steer.
- in_dest  input  2  destination channel 0..3.
- in_ready  output  1  block accepts the byte this cycle.
- out_valid  output  4  bit i set when channel i holds a byte.
- out_data  output  4*WIDTH  channel i payload at bits [WIDTH*i+WIDTH-1 : WIDTH*i].
- out_ready  input  4  bit i set when consumer i takes the byte.
- sent_count  output  32  channel i delivered-byte count at bits [8i+7:8i].

## Operation
- Per channel i: full[i] flag (drives out_valid[i]), data_reg[i] (drives out_data slice), cnt[i] 8-bit.
- in_ready = !full[in_dest] || out_ready[in_dest]. This is combinational and depends only on in_dest and state. It does not depend on in_valid.
- Accept = in_valid && in_ready. On accept, data_reg[in_dest] <= in_data and full[in_dest] <= 1.
- Drain on channel i = full[i] && out_ready[i]. On drain without a same-cycle accept to i, full[i] <= 0 and data_reg[i] holds its value.
- Drain and accept on the same channel in the same cycle: full stays 1, data_reg loads the new byte, and cnt increments.
- Channels are independent. Accept on channel j and drains on any other channels may all happen in the same cycle.
- cnt[i] increments by 1 on each drain of i and wraps 255 -> 0. Accepts do not affect it.
- out_ready[i] while full[i]=0 has no effect.
- in_dest is ignored when in_valid=0. in_ready still reflects in_dest.
- rst_n low at a clock edge sets full, data_reg and cnt on all channels to 0. Any in-flight handshake that cycle is discarded: no accept, no drain, no count.

## Timing
- Reset values: out_valid=4'b0000, out_data=0, sent_count=0. in_ready=1 for any in_dest.
- Latency: a byte accepted at edge N is visible on out_valid/out_data after edge N. The consumer can take it in cycle N+1.
- Throughput: with out_ready[d] held at 1, one byte per cycle into a single channel, no bubbles.
- Backpressure: while full[d]=1 and out_ready[d]=0, in_ready=0 for in_dest=d. The producer must hold in_valid, in_data and in_dest stable until accept.
- out_data[i] is stable while out_valid[i]=1 and out_ready[i]=0.
- sent_count updates one edge after the drain cycle.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles, then out_valid=0000, sent_count=0, and in_ready=1 for in_dest 0..3.
- Single steer: in_dest=2, in_data=8'hA5, out_ready=0000 for one cycle. Next cycle out_valid=0100, slice 2=8'hA5. A second byte to dest 2 sees in_ready=0. Raising out_ready[2] gives in_ready=1 that cycle, and after the edge the channel-2 count is 1.
- Streaming: dest 1, out_ready[1]=1, bytes 0x00..0x0F on 16 consecutive cycles. in_ready stays 1, bytes emerge in order one cycle later, and the channel-1 count reaches 16.
- Concurrency: channel 0 and channel 3 full. In one cycle, drain channel 0 and accept 8'h3C into channel 3 with out_ready[3]=1. Result: out_valid[0]=0, channel 3 holds 3C, counts 0 and 3 each +1.
- Wrap: deliver 256 bytes on channel 1. The count goes 255 -> 0, and other channels stay unchanged.
- Reset mid-operation: with all four channels full and out_ready=1111, assert rst_n=0 for one edge. Then out_valid=0000 and sent_count=0, with no count increments from that cycle.

Source files
------------

// File: rtl/demux4x8bit_stream.sv
// Registered 1-to-4 byte demultiplexer with valid/ready on both sides.
// Each channel holds one byte and keeps a wrapping count of delivered bytes.

module demux4x8bit_stream_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic [7:0]       cnt
);
  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             drain;

  always_comb begin
    drain  = full_q && out_ready;
    full_d = full_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (drain) begin
      full_d = 1'b0;
      cnt_d  = cnt_q + 8'd1;
    end
    // A same-cycle accept wins over the drain's clear of full.
    if (acc) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign full = full_q;
  assign data = data_q;
  assign cnt  = cnt_q;
endmodule

module demux4x8bit_stream #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_dest,
  output logic               in_ready,
  output logic [3:0]         out_valid,
  output logic [4*WIDTH-1:0] out_data,
  input  logic [3:0]         out_ready,
  output logic [31:0]        sent_count
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]            acc;
  logic [NUM_LANES-1:0]            full;
  logic [NUM_LANES-1:0][WIDTH-1:0] data;
  logic [NUM_LANES-1:0][7:0]       cnt;
  logic                            accept;

  // Ready depends only on the addressed channel's state, never on in_valid.
  assign in_ready = !full[in_dest] || out_ready[in_dest];
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign acc[i] = accept && (in_dest == 2'(i));

    demux4x8bit_stream_lane #(.WIDTH(WIDTH)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .acc      (acc[i]),
      .in_data  (in_data),
      .out_ready(out_ready[i]),
      .full     (full[i]),
      .data     (data[i]),
      .cnt      (cnt[i])
    );
  end

  assign out_valid  = full;
  assign out_data   = data;
  assign sent_count = cnt;
endmodule

// File: tb/tb_demux4x8bit_stream.sv
// Randomized and directed bench for demux4x8bit_stream against a
// one-slot-per-channel mailbox model with delivery tallies.

module tb_demux4x8bit_stream;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_dest;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_ready;
  logic [31:0] sent_count;

  int n_chk = 0;
  int n_err = 0;

  // Model: each channel is a mailbox holding at most one byte, plus a
  // running total of bytes delivered out of it.
  bit         m_has [4];
  logic [7:0] m_val [4];
  int         m_delivered [4];

  always #5 clk = ~clk;

  demux4x8bit_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sent_count(sent_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return !m_has[in_dest] || out_ready[in_dest];
  endfunction

  function automatic logic [7:0] model_cnt(input int ch);
    return 8'(m_delivered[ch] % 256);
  endfunction

  task automatic model_step();
    bit take;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_has[i] = 0; m_val[i] = 8'h00; m_delivered[i] = 0;
      end
    end else begin
      take = in_valid && model_ready();
      // Consumers take first, then the producer's byte lands in its mailbox.
      for (int i = 0; i < 4; i++)
        if (m_has[i] && out_ready[i]) begin
          m_has[i] = 0;
          m_delivered[i]++;
        end
      if (take) begin
        m_has[in_dest] = 1;
        m_val[in_dest] = in_data;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(m_has[i]));
      if (m_has[i]) chk($sformatf("out_data[%0d]", i), 32'(out_data[8*i +: 8]), 32'(m_val[i]));
      chk($sformatf("sent_count[%0d]", i), 32'(sent_count[8*i +: 8]), 32'(model_cnt(i)));
    end
  endtask

  // Called with inputs set just after a falling edge.
  task automatic cycle();
    #1 chk("in_ready", 32'(in_ready), 32'(model_ready()));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  logic [7:0] cnt_before, cnt3_before;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_dest = 2'd0; out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_has[i] = 0; m_val[i] = 8'h00; m_delivered[i] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    cycle();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_sent_count", sent_count, 32'h0);
    rst_n = 1'b1;
    for (int d = 0; d < 4; d++) begin
      in_dest = 2'(d);
      #1 chk("rst_in_ready", 32'(in_ready), 32'h1);
    end

    // Single steer with backpressure
    in_valid = 1'b1; in_dest = 2'd2; in_data = 8'hA5; out_ready = 4'b0000;
    cycle();
    chk("steer_valid", 32'(out_valid), 32'h4);
    chk("steer_data", 32'(out_data[23:16]), 32'hA5);
    in_data = 8'h11;
    #1 chk("bp_in_ready", 32'(in_ready), 32'h0);
    cycle();
    chk("bp_hold_data", 32'(out_data[23:16]), 32'hA5);
    out_ready = 4'b0100;
    #1 chk("drain_in_ready", 32'(in_ready), 32'h1);
    cycle();
    chk("steer_cnt2", 32'(sent_count[23:16]), 32'h1);
    chk("steer_new_data", 32'(out_data[23:16]), 32'h11);
    in_valid = 1'b0;
    cycle();

    // Streaming into channel 1
    in_valid = 1'b1; in_dest = 2'd1; out_ready = 4'b0010;
    for (int b = 0; b < 16; b++) begin
      in_data = 8'(b);
      cycle();
      chk("stream_data", 32'(out_data[15:8]), 32'(b));
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_cnt1", 32'(sent_count[15:8]), 32'd16);

    // Concurrency: ch0 drains while ch3 drains and re-accepts
    out_ready = 4'b0000; in_valid = 1'b1;
    in_dest = 2'd0; in_data = 8'h10; cycle();
    in_dest = 2'd3; in_data = 8'h30; cycle();
    cnt_before  = sent_count[7:0];
    cnt3_before = sent_count[31:24];
    in_data = 8'h3C; out_ready = 4'b1001;
    cycle();
    chk("conc_valid0", 32'(out_valid[0]), 32'h0);
    chk("conc_valid3", 32'(out_valid[3]), 32'h1);
    chk("conc_data3", 32'(out_data[31:24]), 32'h3C);
    chk("conc_cnt0", 32'(sent_count[7:0]), 32'(8'(cnt_before + 8'd1)));
    chk("conc_cnt3", 32'(sent_count[31:24]), 32'(8'(cnt3_before + 8'd1)));
    in_valid = 1'b0; out_ready = 4'b1111;
    cycle();

    // Wrap: 256 deliveries on channel 1 bring its count back around
    cnt_before = sent_count[15:8];
    in_valid = 1'b1; in_dest = 2'd1; out_ready = 4'b0010;
    in_data = 8'($urandom); cycle();
    for (int k = 0; k < 255; k++) begin
      in_data = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("wrap_cnt1", 32'(sent_count[15:8]), 32'(cnt_before));
    chk("wrap_cnt_others", 32'({sent_count[31:16], sent_count[7:0]}),
        32'({model_cnt(3), model_cnt(2), model_cnt(0)}));

    // Randomized traffic with occasional reset
    for (int k = 0; k < 600; k++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      in_dest   = 2'($urandom);
      out_ready = 4'($urandom);
      cycle();
    end
    rst_n = 1'b1;

    // Reset mid-operation with every channel full and every consumer ready
    in_valid = 1'b1; out_ready = 4'b0000;
    for (int d = 0; d < 4; d++) begin
      in_dest = 2'(d); in_data = 8'hC0 + 8'(d);
      cycle();
    end
    chk("pre_rst_full", 32'(out_valid), 32'hF);
    out_ready = 4'b1111; rst_n = 1'b0;
    cycle();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_count", sent_count, 32'h0);
    chk("mid_rst_data", out_data, 32'h0);
    rst_n = 1'b1; in_valid = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
